// File: rtl/dz_pkg.sv
// Shared types and constants for the dot-matrix frame arbiter: state encoding,
// pattern codes and one-hot row constants.
package dz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW_A = 2'd1,
    ST_SHOW_B = 2'd2
  } dz_state_e;

  localparam logic [2:0] CODE_BLANK = 3'd0;
  localparam logic [2:0] CODE_D1    = 3'd1;
  localparam logic [2:0] CODE_D2    = 3'd2;
  localparam logic [2:0] CODE_D3    = 3'd3;
  localparam logic [2:0] CODE_D4    = 3'd4;

  // Active-high one-hot row masks, index = row number.
  localparam logic [7:0][7:0] ROW_OH = {8'h80, 8'h40, 8'h20, 8'h10,
                                        8'h08, 8'h04, 8'h02, 8'h01};

endpackage

// File: rtl/dz_glyph_rom.sv
// Combinational glyph table: pattern code + row index -> 8-bit column mask.
// Codes 0 and 5-7 are blank.
module dz_glyph_rom
  import dz_pkg::*;
(
  input  logic [2:0] code_i,
  input  logic [2:0] row_i,
  output logic [7:0] mask_o
);

  always_comb begin
    mask_o = 8'h00;
    case (code_i)
      CODE_D1: if (row_i >= 3'd1 && row_i <= 3'd6) mask_o = 8'h20;
      CODE_D2:
        case (row_i)
          3'd1, 3'd3, 3'd5: mask_o = 8'h3C;
          3'd2:             mask_o = 8'h04;
          3'd4:             mask_o = 8'h20;
          default:          mask_o = 8'h00;
        endcase
      CODE_D3:
        case (row_i)
          3'd1, 3'd5: mask_o = 8'h3C;
          3'd2, 3'd4: mask_o = 8'h04;
          3'd3:       mask_o = 8'h1C;
          default:    mask_o = 8'h00;
        endcase
      CODE_D4:
        case (row_i)
          3'd1, 3'd4: mask_o = 8'h18;
          3'd2, 3'd3: mask_o = 8'h3C;
          default:    mask_o = 8'h00;
        endcase
      default: mask_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/dz_frame_arb.sv
// Two-requester arbiter for an 8x8 bicolour matrix with row scanning and
// frame-granular grant hold. Define DZ_FRAME_ARB_BLINK_EN to blink requester B.
module dz_frame_arb
  import dz_pkg::*;
#(
  parameter int SCAN_DIV     = 1,
  parameter int HOLD_FRAMES  = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [2:0] code_a,
  input  logic       req_b,
  input  logic [2:0] code_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = ($clog2(HOLD_FRAMES + 1) > 4) ? $clog2(HOLD_FRAMES + 1) : 4;
  localparam logic [FW-1:0] HOLD_M1 = FW'(HOLD_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    row_cnt_q, row_cnt_d;
  dz_state_e     state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [7:0]    row_q, colr_q, colg_q, colr_d, colg_d, mask;
  logic          fdone_q;
  logic          tick, boundary, hold_done, blank_b;

  assign tick      = (pre_q == PW'(SCAN_DIV - 1));
  assign boundary  = tick && (row_cnt_q == 3'd7);
  // frm_q counts frames already completed; the one ending now makes it +1.
  assign hold_done = (frm_q >= HOLD_M1);

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    row_cnt_d = tick ? row_cnt_q + 3'd1 : row_cnt_q;
    state_d   = state_q;
    code_d    = code_q;
    frm_d     = frm_q;
    if (boundary) begin
      if (state_q != ST_IDLE && !hold_done) state_d = state_q;
      else if (req_b)                       state_d = ST_SHOW_B;
      else if (req_a)                       state_d = ST_SHOW_A;
      else                                  state_d = ST_IDLE;
      case (state_d)
        ST_SHOW_A: code_d = code_a;
        ST_SHOW_B: code_d = code_b;
        default:   code_d = CODE_BLANK;
      endcase
      if (state_d != state_q)           frm_d = '0;
      else if (frm_q < FW'(HOLD_FRAMES)) frm_d = frm_q + 1'b1;
    end
  end

`ifdef DZ_FRAME_ARB_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_FRAMES) + 1;
  logic [BW-1:0] blk_q, blk_d;

  always_comb begin
    blk_d = blk_q;
    if (boundary) begin
      if (state_d == ST_SHOW_B && state_q == ST_SHOW_B)
        blk_d = (blk_q == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blk_q + 1'b1;
      else
        blk_d = '0;
    end
  end

  assign blank_b = (blk_d >= BW'(BLINK_FRAMES));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blk_q <= '0;
    else        blk_q <= blk_d;
`else
  assign blank_b = 1'b0;
`endif

  dz_glyph_rom u_rom (
    .code_i (code_d),
    .row_i  (row_cnt_d),
    .mask_o (mask)
  );

  // Colours are computed from next-state values so the registered outputs
  // land together with the new row_cnt.
  always_comb begin
    colr_d = 8'h00;
    colg_d = 8'h00;
    case (state_d)
      ST_SHOW_A: begin
        colg_d = mask;
        if (code_d == CODE_D4) colr_d = mask;
      end
      ST_SHOW_B: if (!blank_b) colr_d = mask;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      row_cnt_q <= 3'd0;
      state_q   <= ST_IDLE;
      code_q    <= CODE_BLANK;
      frm_q     <= '0;
      row_q     <= 8'hFF;
      colr_q    <= 8'h00;
      colg_q    <= 8'h00;
      fdone_q   <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      row_cnt_q <= row_cnt_d;
      state_q   <= state_d;
      code_q    <= code_d;
      frm_q     <= frm_d;
      fdone_q   <= boundary;
      if (tick) begin
        row_q  <= ~ROW_OH[row_cnt_d];
        colr_q <= colr_d;
        colg_q <= colg_d;
      end
    end
  end

  assign gnt_a      = (state_q == ST_SHOW_A);
  assign gnt_b      = (state_q == ST_SHOW_B);
  assign row        = row_q;
  assign colr       = colr_q;
  assign colg       = colg_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_dz_frame_arb.sv
// Bench for dz_frame_arb: frame-level reference model compared every cycle,
// plus directed literal checks at hand-computed cycles.
module tb_dz_frame_arb;

  localparam int SD    = 1;
  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] code_a = 3'd0, code_b = 3'd0;
  logic       gnt_a, gnt_b, frame_done;
  logic [7:0] row, colr, colg;

  int checks = 0;
  int fails  = 0;
  bit started = 1'b0;
  int tn = 0;

  dz_frame_arb #(.SCAN_DIV(SD), .HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .code_a(code_a), .req_b(req_b), .code_b(code_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .row(row), .colr(colr), .colg(colg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [2:0] c, input int r);
    logic [7:0] t [8];
    for (int i = 0; i < 8; i++) t[i] = 8'h00;
    case (c)
      3'd1: for (int i = 1; i <= 6; i++) t[i] = 8'h20;
      3'd2: begin t[1] = 8'h3C; t[2] = 8'h04; t[3] = 8'h3C; t[4] = 8'h20; t[5] = 8'h3C; end
      3'd3: begin t[1] = 8'h3C; t[2] = 8'h04; t[3] = 8'h1C; t[4] = 8'h04; t[5] = 8'h3C; end
      3'd4: begin t[1] = 8'h18; t[2] = 8'h3C; t[3] = 8'h3C; t[4] = 8'h18; end
      default: ;
    endcase
    return t[r];
  endfunction

  // Frame-level model: n = edges since reset release, owner 0/1/2 = idle/A/B,
  // held = full frames completed by the owner, bfr = frames since entering B.
  int n = 0, owner = 0, held = 0, bfr = 0, nxt = 0;
  logic [2:0] mcode = 3'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; owner = 0; held = 0; bfr = 0; mcode = 3'd0;
    end else begin
      n++;
      if (n % (8 * SD) == 0) begin
        if (owner != 0 && held + 1 < HOLD) nxt = owner;
        else if (req_b)                    nxt = 2;
        else if (req_a)                    nxt = 1;
        else                               nxt = 0;
        if (nxt != owner) begin held = 0; bfr = 0; end
        else begin held++; bfr++; end
        owner = nxt;
        mcode = (nxt == 1) ? code_a : (nxt == 2) ? code_b : 3'd0;
      end
    end
  end

  logic [7:0] e_row, e_r, e_g, gm;
  int         r;
  bit         lit;

  always @(negedge clk) begin
    if (started) begin
      e_row = 8'hFF; e_r = 8'h00; e_g = 8'h00;
      if (n >= SD) begin
        r     = (n / SD) % 8;
        e_row = ~(8'h01 << r);
        gm    = glyph(mcode, r);
`ifdef DZ_FRAME_ARB_BLINK_EN
        lit = ((bfr / BLINK) % 2) == 0;
`else
        lit = 1'b1;
`endif
        if (owner == 1) begin e_g = gm; if (mcode == 3'd4) e_r = gm; end
        if (owner == 2 && lit) e_r = gm;
      end
      chk("m_row", row, e_row);
      chk("m_colr", colr, e_r);
      chk("m_colg", colg, e_g);
      chk("m_gnt_a", {7'd0, gnt_a}, {7'd0, owner == 1});
      chk("m_gnt_b", {7'd0, gnt_b}, {7'd0, owner == 2});
      chk("m_fdone", {7'd0, frame_done}, {7'd0, n > 0 && n % (8 * SD) == 0});
    end
  end

  task automatic to_n(input int t);
    while (tn < t) begin @(negedge clk); tn++; end
  endtask

  task automatic release_rst();
    @(negedge clk); #1 rst_n = 1'b1; tn = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0; started = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_row", row, 8'hFF);
    chk("rst_colr", colr, 8'h00);
    chk("rst_gnt", {6'd0, gnt_a, gnt_b}, 8'h00);
    chk("rst_fdone", {7'd0, frame_done}, 8'h00);
    release_rst();

    // idle scan
    to_n(1);  chk("idle_row1", row, 8'hFD);
    to_n(8);  chk("idle_row0", row, 8'hFE); chk("idle_fdone", {7'd0, frame_done}, 8'h01);

    // A amber, granted at next boundary
    to_n(11); req_a = 1'b1; code_a = 3'd4;
    to_n(15); chk("a_pre", {7'd0, gnt_a}, 8'h00);
    to_n(16); chk("a_gnt", {6'd0, gnt_a, gnt_b}, 8'h02);
    to_n(17); chk("a_r1_r", colr, 8'h18); chk("a_r1_g", colg, 8'h18);
    to_n(18); chk("a_r2_r", colr, 8'h3C); chk("a_r2_g", colg, 8'h3C); code_a = 3'd1;
    to_n(19); chk("a_midcode", colr, 8'h3C);
    to_n(20); req_b = 1'b1; code_b = 3'd1;
    to_n(26); chk("a_code1_r", colr, 8'h00); chk("a_code1_g", colg, 8'h20);
    to_n(47); chk("hold_a_47", {6'd0, gnt_a, gnt_b}, 8'h02);
    to_n(48); chk("preempt_48", {6'd0, gnt_a, gnt_b}, 8'h01);
    to_n(50); chk("b_r2_r", colr, 8'h20); chk("b_r2_g", colg, 8'h00);
    to_n(58); chk("blink_f1", colr, 8'h20);
`ifdef DZ_FRAME_ARB_BLINK_EN
    to_n(66); chk("blink_f2", colr, 8'h00);
    to_n(74); chk("blink_f3", colr, 8'h00);
`else
    to_n(66); chk("steady_f2", colr, 8'h20);
    to_n(74); chk("steady_f3", colr, 8'h20);
`endif
    to_n(82); chk("blink_f4", colr, 8'h20);

    // async reset at row 5 of a B frame
    to_n(85); #2 rst_n = 1'b0; #1;
    chk("arst_row", row, 8'hFF);
    chk("arst_gnt", {6'd0, gnt_a, gnt_b}, 8'h00);
    chk("arst_col", colr | colg, 8'h00);
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();

    // both rise in the same frame: B wins
    to_n(3);  req_a = 1'b1; code_a = 3'd4; req_b = 1'b1; code_b = 3'd1;
    to_n(7);  chk("re_idle", {6'd0, gnt_a, gnt_b}, 8'h00);
    to_n(8);  chk("re_gnt_b", {6'd0, gnt_a, gnt_b}, 8'h01);
    to_n(10); chk("both_r2_r", colr, 8'h20); chk("both_r2_g", colg, 8'h00); req_b = 1'b0;
    to_n(35); code_a = 3'd2;
    to_n(39); chk("b_hold_39", {6'd0, gnt_a, gnt_b}, 8'h01);
    to_n(40); chk("b_rel_40", {6'd0, gnt_a, gnt_b}, 8'h02);
    to_n(41); chk("a2_r1_g", colg, 8'h3C); chk("a2_r1_r", colr, 8'h00);
    to_n(42); req_a = 1'b0;
    to_n(71); chk("a_hold_71", {6'd0, gnt_a, gnt_b}, 8'h02);
    to_n(72); chk("a_rel_72", {6'd0, gnt_a, gnt_b}, 8'h00);
    to_n(74); req_a = 1'b1; code_a = 3'd5;
    to_n(80); chk("c5_gnt", {6'd0, gnt_a, gnt_b}, 8'h02);
    to_n(82); chk("c5_blank", colr | colg, 8'h00);
    to_n(84);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
